// File: rtl/t01_tetris_pkg.sv
// Shared types and constants for the t01 piece source: piece types, orientation
// counts, block-type code table and LFSR taps.
package t01_tetris_pkg;

    typedef enum logic [2:0] {
        P_I = 3'd0,
        P_O = 3'd1,
        P_S = 3'd2,
        P_Z = 3'd3,
        P_J = 3'd4,
        P_L = 3'd5,
        P_T = 3'd6
    } piece_t;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_READY  = 2'd1,
        ST_REFILL = 2'd2
    } queue_state_t;

    localparam logic [2:0] ORIENT_CNT [7] = '{3'd2, 3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4};

    // CODE_TABLE is packed per type in I,O,S,Z,J,L,T order; CODE_BASE is each type's first entry.
    localparam logic [4:0] CODE_BASE [7] = '{5'd0, 5'd2, 5'd3, 5'd5, 5'd7, 5'd11, 5'd15};
    localparam logic [4:0] CODE_TABLE [19] = '{
        5'd0,  5'd7,
        5'd1,
        5'd2,  5'd8,
        5'd3,  5'd9,
        5'd4,  5'd10, 5'd11, 5'd12,
        5'd5,  5'd13, 5'd14, 5'd15,
        5'd6,  5'd16, 5'd17, 5'd18
    };

    // feedback = l[15]^l[13]^l[12]^l[10]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [1:0] rot_next(input logic [1:0] rot, input logic [2:0] cnt,
                                            input logic cw);
        logic [2:0] last;
        last = cnt - 3'd1;
        if (cw) begin
            rot_next = ({1'b0, rot} == last) ? 2'd0 : rot + 2'd1;
        end else begin
            rot_next = (rot == 2'd0) ? last[1:0] : rot - 2'd1;
        end
    endfunction

endpackage

// File: rtl/t01_piece_queue_if.sv
// Control/status bundle between the game-control FSM (master) and the piece
// queue (slave).
interface t01_piece_queue_if #(
    parameter int QUEUE_DEPTH = 3,
    parameter int LFSR_WIDTH  = 16
);
    logic                     en;
    logic                     seed_load;
    logic [LFSR_WIDTH-1:0]    seed;
    logic                     pop;
    logic                     rotate_cw;
    logic                     rotate_ccw;
    logic                     ready;
    logic                     cur_valid;
    logic [2:0]               cur_type;
    logic [1:0]               cur_rot;
    logic [4:0]               cur_code;
    logic [3*QUEUE_DEPTH-1:0] preview;

    modport master (
        output en, seed_load, seed, pop, rotate_cw, rotate_ccw,
        input  ready, cur_valid, cur_type, cur_rot, cur_code, preview
    );

    modport slave (
        input  en, seed_load, seed, pop, rotate_cw, rotate_ccw,
        output ready, cur_valid, cur_type, cur_rot, cur_code, preview
    );
endinterface

// File: rtl/t01_rot_code.sv
// Combinational (piece type, rotation) -> 5-bit block-type code lookup; also
// usable by the rotation-collision check.
module t01_rot_code
    import t01_tetris_pkg::*;
(
    input  piece_t     piece,
    input  logic [1:0] rot,
    output logic [4:0] code
);
    logic [4:0] idx;

    always_comb begin
        idx  = CODE_BASE[piece] + {3'd0, rot};
        code = CODE_TABLE[idx];
    end
endmodule

// File: rtl/t01_piece_queue.sv
// 7-bag piece source with LFSR draw, preview queue and active-piece rotation.
//   state     | meaning
//   ST_FILL   | drawing current piece then every preview slot after reset
//   ST_READY  | queue full, pop accepted
//   ST_REFILL | one draw into the last preview slot after a pop
module t01_piece_queue
    import t01_tetris_pkg::*;
#(
    parameter int                    QUEUE_DEPTH = 3,
    parameter int                    LFSR_WIDTH  = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             n_rst,
    t01_piece_queue_if.slave bus
);
    localparam logic [2:0] DRAW_LAST = 3'(QUEUE_DEPTH);

    queue_state_t          state, state_nxt;
    logic [LFSR_WIDTH-1:0] lfsr;
    logic [6:0]            mask, mask_set, mask_nxt;
    logic [2:0]            retry_left;
    logic [2:0]            draw_cnt;
    logic                  valid_q;
    piece_t                cur_q;
    logic [1:0]            rot_q;
    piece_t                prev_q [QUEUE_DEPTH];

    logic                  ready, draw_active, draw_hit, draw_take, pop_ok;
    logic [2:0]            cand;
    logic                  cand_ok;
    piece_t                low_free, draw_type;
    logic [4:0]            code;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        draw_active = 1'b0;
        draw_take   = 1'b0;
        pop_ok      = 1'b0;
        case (state)
            ST_FILL: begin
                draw_active = bus.en;
                draw_take   = bus.en && draw_hit;
                if (draw_take && draw_cnt == DRAW_LAST) state_nxt = ST_READY;
            end
            ST_READY: begin
                ready  = 1'b1;
                pop_ok = bus.en && bus.pop;
                if (pop_ok) state_nxt = ST_REFILL;
            end
            ST_REFILL: begin
                draw_active = bus.en;
                draw_take   = bus.en && draw_hit;
                if (draw_take) state_nxt = ST_READY;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // Rejected candidates fall back to the lowest unused type once retries run out.
    always_comb begin
        cand     = lfsr[2:0];
        cand_ok  = (cand != 3'd7) && !mask[cand];
        low_free = P_I;
        for (int i = 6; i >= 0; i--) begin
            if (!mask[i]) low_free = piece_t'(3'(i));
        end
        draw_hit  = cand_ok || (retry_left == 3'd0);
        draw_type = cand_ok ? piece_t'(cand) : low_free;
        mask_set  = mask | (7'd1 << draw_type);
        mask_nxt  = (mask_set == 7'h7F) ? 7'h00 : mask_set;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr       <= SEED;
            mask       <= 7'h00;
            retry_left <= 3'd7;
            draw_cnt   <= 3'd0;
            valid_q    <= 1'b0;
            cur_q      <= P_I;
            rot_q      <= 2'd0;
            for (int i = 0; i < QUEUE_DEPTH; i++) prev_q[i] <= P_I;
        end else if (bus.en) begin
            if (bus.seed_load) begin
                lfsr <= (bus.seed == '0) ? SEED : bus.seed;
            end else begin
                lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
            end

            if (draw_active) begin
                if (draw_take) begin
                    mask       <= mask_nxt;
                    retry_left <= 3'd7;
                end else begin
                    retry_left <= retry_left - 3'd1;
                end
            end

            if (draw_take) begin
                if (state == ST_FILL) begin
                    draw_cnt <= draw_cnt + 3'd1;
                    if (draw_cnt == 3'd0) begin
                        cur_q   <= draw_type;
                        rot_q   <= 2'd0;
                        valid_q <= 1'b1;
                    end
                    for (int i = 0; i < QUEUE_DEPTH; i++) begin
                        if (draw_cnt == 3'(i + 1)) prev_q[i] <= draw_type;
                    end
                end else begin
                    prev_q[QUEUE_DEPTH-1] <= draw_type;
                end
            end

            if (pop_ok) begin
                cur_q <= prev_q[0];
                rot_q <= 2'd0;
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) prev_q[i] <= prev_q[i+1];
            end else if (valid_q && (bus.rotate_cw != bus.rotate_ccw)) begin
                rot_q <= rot_next(rot_q, ORIENT_CNT[cur_q], bus.rotate_cw);
            end
        end
    end

    t01_rot_code u_rot_code (
        .piece (cur_q),
        .rot   (rot_q),
        .code  (code)
    );

    assign bus.ready     = ready;
    assign bus.cur_valid = valid_q;
    assign bus.cur_type  = cur_q;
    assign bus.cur_rot   = rot_q;
    assign bus.cur_code  = valid_q ? code : 5'd0;

    for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_preview
        assign bus.preview[3*g +: 3] = prev_q[g];
    end
endmodule

// File: tb/tb_t01_piece_queue.sv
// Directed bench for t01_piece_queue: hand-derived first deal, bag permutations,
// rotation codes, pop handshake, seed repeatability and async reset.
module tb_t01_piece_queue;
    localparam int QD = 3;

    logic clk = 1'b0;
    logic n_rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   deal_q[$];
    int   run_a[$];
    int   run_b[$];

    t01_piece_queue_if #(.QUEUE_DEPTH(QD), .LFSR_WIDTH(16)) bus ();

    t01_piece_queue #(.QUEUE_DEPTH(QD), .LFSR_WIDTH(16), .SEED(16'hACE1)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int slot(input int i);
        return int'(bus.preview[3*i +: 3]);
    endfunction

    task automatic wait_ready(input int budget, input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, int'(bus.ready), 1);
    endtask

    task automatic pop_one();
        int p0, p1, p2;
        p0 = slot(0);
        p1 = slot(1);
        p2 = slot(2);
        bus.pop = 1'b1;
        cycle();
        bus.pop = 1'b0;
        chk("pop_cur", int'(bus.cur_type), p0);
        chk("pop_rot", int'(bus.cur_rot), 0);
        chk("pop_code", int'(bus.cur_code), p0);
        chk("pop_shift0", slot(0), p1);
        chk("pop_shift1", slot(1), p2);
        chk("refill_busy", int'(bus.ready), 0);
        wait_ready(8, "refill_ready");
        deal_q.push_back(slot(2));
    endtask

    task automatic start_run(input logic load, input logic [15:0] s);
        deal_q.delete();
        bus.en         = 1'b1;
        bus.pop        = 1'b0;
        bus.rotate_cw  = 1'b0;
        bus.rotate_ccw = 1'b0;
        bus.seed_load  = 1'b0;
        n_rst = 1'b0;
        cycle();
        cycle();
        n_rst = 1'b1;
        bus.seed_load = load;
        bus.seed      = s;
        cycle();
        bus.seed_load = 1'b0;
        wait_ready(40, "fill_ready");
        chk("fill_valid", int'(bus.cur_valid), 1);
        deal_q.push_back(int'(bus.cur_type));
        for (int i = 0; i < QD; i++) deal_q.push_back(slot(i));
    endtask

    task automatic deal_run(input logic load, input logic [15:0] s);
        start_run(load, s);
        for (int i = 0; i < 24; i++) pop_one();
    endtask

    task automatic check_bags();
        logic [7:0] seen;
        for (int g = 0; g < 4; g++) begin
            seen = 8'h00;
            for (int k = 0; k < 7; k++) seen = seen | (8'd1 << deal_q[7*g+k]);
            chk($sformatf("bag_perm%0d", g), int'(seen), 32'h7F);
        end
    endtask

    task automatic pop_until(input int t);
        int n;
        n = 0;
        while (int'(bus.cur_type) != t && n < 14) begin
            pop_one();
            n++;
        end
        chk("find_type", int'(bus.cur_type), t);
    endtask

    task automatic rot_step(input logic cw, input logic ccw, input int exp_code, input string tag);
        bus.rotate_cw  = cw;
        bus.rotate_ccw = ccw;
        cycle();
        bus.rotate_cw  = 1'b0;
        bus.rotate_ccw = 1'b0;
        chk(tag, int'(bus.cur_code), exp_code);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, p1, p2;
        n_rst          = 1'b0;
        bus.en         = 1'b0;
        bus.seed_load  = 1'b0;
        bus.seed       = 16'h0000;
        bus.pop        = 1'b0;
        bus.rotate_cw  = 1'b0;
        bus.rotate_ccw = 1'b0;
        cycle();
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_valid", int'(bus.cur_valid), 0);
        chk("rst_type", int'(bus.cur_type), 0);
        chk("rst_rot", int'(bus.cur_rot), 0);
        chk("rst_code", int'(bus.cur_code), 0);
        chk("rst_preview", int'(bus.preview), 0);

        // en low after release: nothing moves, LFSR included
        n_rst = 1'b1;
        repeat (3) cycle();
        chk("en0_valid", int'(bus.cur_valid), 0);

        // From 16'hACE1: draws 1 | 3 | 7 rej | 7 rej | 6 | 4 -> ready after 6 edges
        bus.en = 1'b1;
        cycle();
        chk("first_valid", int'(bus.cur_valid), 1);
        chk("first_type", int'(bus.cur_type), 1);
        chk("first_code", int'(bus.cur_code), 1);
        chk("first_ready", int'(bus.ready), 0);
        repeat (4) cycle();
        chk("edge5_ready", int'(bus.ready), 0);
        chk("edge5_slot0", slot(0), 3);
        chk("edge5_slot1", slot(1), 6);
        cycle();
        chk("edge6_ready", int'(bus.ready), 1);
        chk("edge6_preview", int'(bus.preview), 32'h133);
        chk("edge6_type", int'(bus.cur_type), 1);

        // en low in READY ignores pop and rotate
        bus.en = 1'b0;
        bus.pop = 1'b1;
        bus.rotate_cw = 1'b1;
        repeat (3) cycle();
        bus.pop = 1'b0;
        bus.rotate_cw = 1'b0;
        chk("freeze_ready", int'(bus.ready), 1);
        chk("freeze_type", int'(bus.cur_type), 1);
        chk("freeze_rot", int'(bus.cur_rot), 0);
        chk("freeze_preview", int'(bus.preview), 32'h133);
        bus.en = 1'b1;

        // pop held for two cycles: only one shift
        p0 = slot(0);
        p1 = slot(1);
        p2 = slot(2);
        bus.pop = 1'b1;
        cycle();
        cycle();
        bus.pop = 1'b0;
        chk("dpop_cur", int'(bus.cur_type), p0);
        chk("dpop_slot0", slot(0), p1);
        chk("dpop_slot1", slot(1), p2);
        wait_ready(7, "dpop_ready");
        chk("dpop_slot0_after", slot(0), p1);

        // 28 deals from reset seed: four full bags
        deal_run(1'b0, 16'h0000);
        check_bags();

        // rotation codes
        pop_until(6);
        rot_step(1'b1, 1'b0, 16, "t_cw1");
        rot_step(1'b1, 1'b0, 17, "t_cw2");
        rot_step(1'b1, 1'b0, 18, "t_cw3");
        rot_step(1'b1, 1'b0, 6, "t_cw4");
        rot_step(1'b0, 1'b1, 18, "t_ccw");
        chk("t_rot", int'(bus.cur_rot), 3);
        pop_until(1);
        rot_step(1'b1, 1'b0, 1, "o_cw");
        pop_until(0);
        rot_step(1'b1, 1'b0, 7, "i_cw1");
        rot_step(1'b1, 1'b0, 0, "i_cw2");
        rot_step(1'b1, 1'b1, 0, "i_both");
        rot_step(1'b0, 1'b1, 7, "i_ccw");
        pop_until(4);
        rot_step(1'b0, 1'b1, 12, "j_ccw");
        // rotate with an accepted pop: pop wins
        bus.rotate_cw = 1'b1;
        pop_one();
        bus.rotate_cw = 1'b0;

        // identical seeds give identical deals; zero seed behaves as SEED
        deal_run(1'b1, 16'h1234);
        check_bags();
        run_a = deal_q;
        deal_run(1'b1, 16'h1234);
        run_b = deal_q;
        for (int i = 0; i < 28; i++) chk($sformatf("seed_rep%0d", i), run_b[i], run_a[i]);
        deal_run(1'b1, 16'h0000);
        run_a = deal_q;
        deal_run(1'b1, 16'hACE1);
        run_b = deal_q;
        for (int i = 0; i < 28; i++) chk($sformatf("seed_zero%0d", i), run_a[i], run_b[i]);

        // async reset during REFILL
        start_run(1'b0, 16'h0000);
        bus.pop = 1'b1;
        cycle();
        bus.pop = 1'b0;
        chk("mid_refill", int'(bus.ready), 0);
        n_rst = 1'b0;
        #1;
        chk("arst_ready", int'(bus.ready), 0);
        chk("arst_valid", int'(bus.cur_valid), 0);
        chk("arst_type", int'(bus.cur_type), 0);
        chk("arst_rot", int'(bus.cur_rot), 0);
        chk("arst_code", int'(bus.cur_code), 0);
        chk("arst_preview", int'(bus.preview), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
